// File: rtl/if_id_queue_if.sv
// Fetch/decode handshake bundle for if_id_queue: fetch-side word, decode-side head,
// flush and occupancy. The queue takes the slave modport, its environment the master.
interface if_id_queue_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          if_valid;
    logic          if_ready;
    logic [31:0]   if_inst;
    logic [31:0]   if_pc;
    logic [31:0]   if_pc4;
    logic          flush;
    logic          id_valid;
    logic          id_ready;
    logic [31:0]   id_inst;
    logic [31:0]   id_pc;
    logic [31:0]   id_pc4;
    logic [CW-1:0] count;

    modport master (
        output if_valid, if_inst, if_pc, if_pc4, flush, id_ready,
        input  if_ready, id_valid, id_inst, id_pc, id_pc4, count
    );

    modport slave (
        input  if_valid, if_inst, if_pc, if_pc4, flush, id_ready,
        output if_ready, id_valid, id_inst, id_pc, id_pc4, count
    );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: DEPTH-entry circular buffer of {inst, pc, pc4} with
// first-word fall-through head. Optional macro IF_ID_NOP_FILL_EN shows a NOP bubble when empty.
module if_id_queue #(
    parameter int          DEPTH    = 2,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;
    logic w_wr_en;

    logic [31:0] w_ent_inst [DEPTH];
    logic [31:0] w_ent_pc   [DEPTH];
    logic [31:0] w_ent_pc4  [DEPTH];

    logic [31:0] w_head_inst;
    logic [31:0] w_head_pc;
    logic [31:0] w_head_pc4;

    assign w_full  = (r_count == FULL_COUNT);
    assign w_empty = (r_count == '0);
    assign w_push  = bus.if_valid && !w_full;
    assign w_pop   = bus.id_ready && !w_empty;
    // A flushed push must not land in storage either, not just be uncounted.
    assign w_wr_en = w_push && !bus.flush;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [31:0] r_inst;
            logic [31:0] r_pc;
            logic [31:0] r_pc4;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_inst <= '0;
                    r_pc   <= '0;
                    r_pc4  <= '0;
                end else if (w_wr_en && (r_wr_ptr == PW'(gi))) begin
                    r_inst <= bus.if_inst;
                    r_pc   <= bus.if_pc;
                    r_pc4  <= bus.if_pc4;
                end
            end

            assign w_ent_inst[gi] = r_inst;
            assign w_ent_pc[gi]   = r_pc;
            assign w_ent_pc4[gi]  = r_pc4;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head_inst = w_ent_inst[r_rd_ptr];
    assign w_head_pc   = w_ent_pc[r_rd_ptr];
    assign w_head_pc4  = w_ent_pc4[r_rd_ptr];

    assign bus.if_ready = !w_full;
    assign bus.id_valid = !w_empty;
    assign bus.count    = r_count;

`ifdef IF_ID_NOP_FILL_EN
    assign bus.id_inst = w_empty ? NOP_INST : w_head_inst;
    assign bus.id_pc   = w_empty ? 32'h0 : w_head_pc;
    assign bus.id_pc4  = w_empty ? 32'h0 : w_head_pc4;
`else
    assign bus.id_inst = w_head_inst;
    assign bus.id_pc   = w_head_pc;
    assign bus.id_pc4  = w_head_pc4;
`endif
endmodule

// File: doc/if_id_queue.md
# if_id_queue

Instruction queue between the fetch stage and the decode stage of the pipelined core. It captures each fetched instruction together with its PC and PC+4 into a small circular buffer with valid/ready handshakes on both sides. Decode can stall without the fetch stage losing a word. A synchronous flush from branch/jump resolution discards all in-flight entries.

## Interface
- `DEPTH`, default 2: number of entries; power of two, ≥ 2.
- `NOP_INST`, default 32'h0000_0013: instruction word presented on an empty queue when NOP fill is compiled in.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `if_valid`  in  1  fetch presents a word this cycle.
- `if_ready`  out  1  queue accepts a word this cycle.
- `if_inst`  in  32  fetched instruction.
- `if_pc`  in  32  PC of `if_inst`.
- `if_pc4`  in  32  PC+4 of `if_inst`.
- `flush`  in  1  discard all entries (taken branch/jump).
- `id_valid`  out  1  head entry is valid.
- `id_ready`  in  1  decode consumes the head this cycle.
- `id_inst`  out  32  head instruction.
- `id_pc`  out  32  head PC.
- `id_pc4`  out  32  head PC+4.
- `count`  out  $clog2(DEPTH)+1  occupied entries, 0..DEPTH.

## Operation
- Storage: DEPTH entries of {inst, pc, pc4}, with write pointer `wr_ptr`, read pointer `rd_ptr` (each $clog2(DEPTH) bits) and occupancy `count`.
- Push = `if_valid && if_ready`. The word is written at `wr_ptr`, then `wr_ptr` increments.
- Pop = `id_valid && id_ready`. `rd_ptr` increments.
- `if_ready = (count != DEPTH)`. It depends on state only; there is no combinational path from `id_ready`.
- `id_valid = (count != 0)`. `id_inst`, `id_pc` and `id_pc4` are driven from entry `rd_ptr` (first-word fall-through).
- Count update:
  - push only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- Pointer wrap: at DEPTH−1 a pointer wraps to 0 by natural modulo-2^n overflow.
- Full (count = DEPTH): `if_ready = 0`, no push. A pop in the same cycle frees one entry; `if_ready` rises the next cycle.
- Empty (count = 0): `id_valid = 0`, no pop. A push in the same cycle is visible at the head the next cycle.
- `flush = 1`: next state is `count = 0`, `wr_ptr = rd_ptr = 0`.
  - Any push or pop in the same cycle is discarded.
  - Storage contents are not cleared.
  - Flush has priority over push and pop.
- Reset (`rst_n = 0` at a clock edge) clears pointers, `count` and every storage entry to 0. It has priority over flush. Reset mid-stream drops all entries.
- `if_inst` / `if_pc` / `if_pc4` are sampled only on a push. They may change freely otherwise.

## Timing
- Reset values:
  - `if_ready` = 1
  - `id_valid` = 0
  - `count` = 0
  - `id_inst` = 0, or `NOP_INST` with fill enabled
  - `id_pc` = 0
  - `id_pc4` = 0
- Latency: a word pushed at edge N is presented with `id_valid = 1` after edge N; minimum fetch-to-decode latency is 1 cycle.
- Throughput: one push and one pop per cycle sustained, at any occupancy 1..DEPTH−1.
- Handshake:
  - Fetch holds `if_inst`, `if_pc` and `if_pc4` stable while `if_valid && !if_ready`.
  - The queue holds its head outputs stable while `id_valid && !id_ready`.
- Flush at edge N: `id_valid = 0` and `if_ready = 1` after N. The first post-flush word can be pushed at edge N+1.

## Configuration
- Macro: `IF_ID_NOP_FILL_EN`.
- Defined: when `id_valid = 0`, `id_inst = NOP_INST`, `id_pc = 0` and `id_pc4 = 0`. Decode may ignore `id_valid` and still execute a harmless bubble.
- Undefined: outputs always show entry `rd_ptr`, stale data included. Decode must qualify everything with `id_valid`.

## Test plan
- Reset, then push {0x00500093, pc 0x0, pc4 0x4} with `id_ready = 1`:
  - `id_valid = 1` one cycle later with those values.
  - `count` 1 → 0 after the pop.
- `id_ready = 0`, push 0x11, then 0x22 (DEPTH = 2):
  - `count = 2`, `if_ready = 0`.
  - Head stays 0x11 until `id_ready = 1`, then 0x22 is presented next.
- Continuous push/pop for 10 words, pc 0x0..0x24:
  - `count` stays 1.
  - Output order matches input order across pointer wrap.
- Queue holding 2 entries, assert `flush` together with `if_valid`:
  - Next cycle `count = 0`, `id_valid = 0`, `if_ready = 1`.
  - The pushed word never appears.
- Full queue, pop and push 0x33 the same cycle:
  - Push is blocked (`if_ready = 0`).
  - `count` becomes 1; `if_ready = 1` next cycle.
- Reset asserted while `count = 2`, with `IF_ID_NOP_FILL_EN`:
  - Next cycle `id_valid = 0` and `id_inst = 0x00000013`.
  - Without the macro, `id_inst = 0x00000000`.
